// File: rtl/rom_load_arb.sv
// rom_load_arb: arbitrates a single-port ROM RAM between the HPS download
// path (ioctl_*) and the game core's read port (cpu_*). It also captures the
// title number and holds the core in reset until a download has settled.
//
// Optional feature: define ROM_LOAD_CKSUM_EN to build a 16-bit running sum of
// every byte written to the ROM. Without it, cksum is tied to zero and no
// adder is built.
module rom_load_arb #(
    parameter int AW   = 17,
    parameter int HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,

    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,

    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_dout,

    output logic [3:0]    tno,
    output logic          core_reset,
    output logic          err,
    output logic [15:0]   cksum
);

    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD1,
        RD2
    } state_t;

    state_t        state;

    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;

    logic [CW-1:0] hold_cnt;

    logic          in_range;
    logic          rom_wr;
    logic          title_wr;
    logic          capture;
    logic          drop;
    logic          launch_wr;
    logic          core_hold;
    logic          start_rd;

    // Download strobe decode. Bytes beyond the ROM space are simply not
    // considered ROM writes, so they neither fill the buffer nor raise err.
    assign in_range  = (ioctl_addr >> AW) == 25'd0;
    assign rom_wr    = ioctl_wr & (ioctl_index == 8'd0) & in_range;
    assign title_wr  = ioctl_wr & (ioctl_index == 8'd1);
    assign capture   = rom_wr & ~buf_valid;
    assign drop      = rom_wr & buf_valid;

    // A pending buffered write always takes the RAM port first when idle.
    assign launch_wr = (state == IDLE) & buf_valid;

    // The core is held while downloading and while the settle counter runs.
    assign core_hold  = ioctl_download | (hold_cnt != '0);
    assign core_reset = reset | core_hold;

    // A read may start only when the core is running. cpu_req is still
    // asserted during the ack cycle, so a new read is not started then.
    assign start_rd  = cpu_req & ~cpu_ack & ~core_hold;

    // Backpressure to the loader mirrors the buffer occupancy directly.
    assign ioctl_wait = buf_valid;

    // One-entry write buffer: filled by an accepted ROM byte, emptied when
    // its contents are moved into the RAM port registers on entering WR.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= 8'd0;
        end else begin
            if (launch_wr) begin
                buf_valid <= 1'b0;
            end
            if (capture) begin
                buf_valid <= 1'b1;
                buf_addr  <= ioctl_addr[AW-1:0];
                buf_data  <= ioctl_dout;
            end
        end
    end

    // Sticky overflow flag: set whenever a ROM byte arrives with the buffer full.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end

    // Title number register, loaded straight from the download byte.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tno <= 4'd0;
        end else if (title_wr) begin
            tno <= ioctl_dout[3:0];
        end
    end

    // Settle counter: pinned at HOLD while downloading (which also restarts
    // it on any new download), then counts down once the last byte is out.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt <= CW'(HOLD);
        end else if (ioctl_download) begin
            hold_cnt <= CW'(HOLD);
        end else if (!buf_valid && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // RAM port sequencer with registered outputs. The RAM port registers are
    // loaded on the transition into WR/RD1 so they are valid during that state;
    // read data is captured in RD2 and presented with a one-cycle ack pulse.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 8'd0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_wr) begin
                        state    <= WR;
                        mem_we   <= 1'b1;
                        mem_addr <= buf_addr;
                        mem_din  <= buf_data;
                    end else if (start_rd) begin
                        state    <= RD1;
                        mem_addr <= cpu_addr;
                    end
                end
                WR: begin
                    state <= IDLE;
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    cpu_rdata <= mem_dout;
                    cpu_ack   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_LOAD_CKSUM_EN
    logic        dl_q;
    logic [15:0] cksum_q;

    // Running byte sum of ROM writes, restarted at the start of each download.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q    <= 1'b0;
            cksum_q <= 16'd0;
        end else begin
            dl_q <= ioctl_download;
            if (ioctl_download && !dl_q) begin
                cksum_q <= 16'd0;
            end else if (launch_wr) begin
                cksum_q <= cksum_q + {8'd0, buf_data};
            end
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 16'd0;
`endif

endmodule

// File: tb/tb_rom_load_arb.sv
// tb_rom_load_arb: self-checking bench for rom_load_arb. A behavioural RAM
// sits on the mem_* port; the expected ROM image, title number, error flag and
// checksum are kept as a simple model driven by the bytes the bench sends.
`timescale 1ns/1ps
module tb_rom_load_arb;

    localparam int AW    = 17;
    localparam int HOLD  = 16;
    localparam int MEMSZ = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;
    logic [3:0]    tno;
    logic          core_reset;
    logic          err;
    logic [15:0]   cksum;

    int errors = 0;
    int checks = 0;

    logic [7:0]    ram   [0:MEMSZ-1];
    logic [7:0]    model [0:MEMSZ-1];
    logic [3:0]    exp_tno;
    logic          exp_err;
    logic [15:0]   exp_sum;
    logic [AW+7:0] we_log[$];
    logic [AW+7:0] exp_we[$];
    logic [AW-1:0] written[$];
    logic          prev_we = 1'b0;
    logic          we_double = 1'b0;

    rom_load_arb #(.AW(AW), .HOLD(HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_rdata      (cpu_rdata),
        .cpu_ack        (cpu_ack),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .mem_dout       (mem_dout),
        .tno            (tno),
        .core_reset     (core_reset),
        .err            (err),
        .cksum          (cksum)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    // Record every write cycle seen on the RAM port, and flag any pulse wider than one cycle.
    always @(negedge clk_sys) begin
        if (mem_we) we_log.push_back({mem_addr, mem_din});
        if (mem_we && prev_we) we_double <= 1'b1;
        prev_we <= mem_we;
    end

    function automatic logic [15:0] expected_cksum();
`ifdef ROM_LOAD_CKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Send one loader byte and update the model as an accepted byte.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
        ioctl_wr    = 1'b1;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_index = idx;
        tick();
        ioctl_wr = 1'b0;
        if (idx == 8'd1) begin
            exp_tno = d[3:0];
        end else if (idx == 8'd0 && a < 25'(MEMSZ)) begin
            model[a[AW-1:0]] = d;
            exp_we.push_back({a[AW-1:0], d});
            exp_sum = exp_sum + 16'(d);
        end
    endtask

    // Issue a core read and report its latency, data and whether ack lingered.
    task automatic do_read(input logic [AW-1:0] a, output int lat, output logic [7:0] d,
                           output logic ack_after);
        cpu_req  = 1'b1;
        cpu_addr = a;
        lat = 0;
        while (cpu_ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        d = cpu_rdata;
        cpu_req = 1'b0;
        tick();
        ack_after = cpu_ack;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks += 10;
        if (mem_we !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== '0)      begin errors++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
        if (mem_din !== 8'd0)     begin errors++; $display("[TB] FAIL rst_mem_din: got %h want 0", mem_din); end
        if (cpu_ack !== 1'b0)     begin errors++; $display("[TB] FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
        if (cpu_rdata !== 8'd0)   begin errors++; $display("[TB] FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
        if (ioctl_wait !== 1'b0)  begin errors++; $display("[TB] FAIL rst_wait: got %b want 0", ioctl_wait); end
        if (tno !== 4'd0)         begin errors++; $display("[TB] FAIL rst_tno: got %h want 0", tno); end
        if (err !== 1'b0)         begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        if (cksum !== 16'd0)      begin errors++; $display("[TB] FAIL rst_cksum: got %h want 0", cksum); end
        if (core_reset !== 1'b1)  begin errors++; $display("[TB] FAIL rst_core_reset: got %b want 1", core_reset); end
        reset = 1'b0;
        exp_tno = 4'd0;
        exp_err = 1'b0;
        exp_sum = 16'd0;
        tick();
    endtask

    task automatic test_download();
        ioctl_download = 1'b1;
        tick();
        exp_sum = 16'd0;
        we_log.delete();
        exp_we.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(25'(i), 8'((i + 1) * 17), 8'd0);
            idle(3);
        end
        idle(2);
        checks++;
        if (we_log.size() != exp_we.size()) begin
            errors++; $display("[TB] FAIL dl_we_count: got %0d pulses want %0d", we_log.size(), exp_we.size());
        end else begin
            foreach (exp_we[i]) begin
                checks++;
                if (we_log[i] !== exp_we[i]) begin errors++; $display("[TB] FAIL dl_we_%0d: got %h want %h", i, we_log[i], exp_we[i]); end
            end
        end
        checks += 2;
        if (cksum !== expected_cksum()) begin errors++; $display("[TB] FAIL dl_cksum: got %h want %h", cksum, expected_cksum()); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL dl_err: got %b want 0", err); end
    endtask

    task automatic test_title();
        we_log.delete();
        send_byte(25'h0, 8'h04, 8'd1);
        idle(2);
        checks++;
        if (tno !== 4'd4) begin errors++; $display("[TB] FAIL title_tno: got %h want 4", tno); end
        send_byte(25'h3, 8'h09, 8'd2);
        idle(3);
        checks += 2;
        if (tno !== exp_tno) begin errors++; $display("[TB] FAIL title_ignored_idx: got %h want %h", tno, exp_tno); end
        if (we_log.size() != 0) begin errors++; $display("[TB] FAIL title_no_we: got %0d pulses want 0", we_log.size()); end
    endtask

    task automatic test_hold_and_read();
        int         lat;
        logic [7:0] d;
        logic       ack_after;
        int         left;
        ioctl_download = 1'b0;
        left = HOLD;
        while (left > 0) begin
            checks++;
            if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL hold_high: got %b want 1 with %0d cycles left", core_reset, left); end
            tick();
            left--;
        end
        checks++;
        if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got %b want 0 after %0d cycles", core_reset, HOLD); end
        do_read(17'h00002, lat, d, ack_after);
        checks += 3;
        if (lat != 3) begin errors++; $display("[TB] FAIL read_latency: got %0d want 3", lat); end
        if (d !== model[2]) begin errors++; $display("[TB] FAIL read_data: got %h want %h", d, model[2]); end
        if (ack_after !== 1'b0) begin errors++; $display("[TB] FAIL read_ack_width: got %b want 0", ack_after); end
    endtask

    task automatic test_out_of_range();
        int         lat;
        logic [7:0] d;
        logic       ack_after;
        we_log.delete();
        send_byte(25'h20000, 8'h5A, 8'd0);
        checks++;
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL oor_wait: got %b want 0", ioctl_wait); end
        send_byte(25'h20000 | 25'($urandom_range(0, 32'h1FFFF)), 8'($urandom), 8'd0);
        idle(3);
        checks += 2;
        if (we_log.size() != 0) begin errors++; $display("[TB] FAIL oor_no_we: got %0d pulses want 0", we_log.size()); end
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err: got %b want 0", err); end
        do_read(17'h00000, lat, d, ack_after);
        checks++;
        if (d !== model[0]) begin errors++; $display("[TB] FAIL oor_alias: got %h want %h", d, model[0]); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0;
        logic [7:0]    d0;
        a0 = AW'(16 + 2 * $urandom_range(0, 1000));
        d0 = 8'($urandom);
        we_log.delete();
        exp_we.delete();
        ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 25'(a0); ioctl_dout = d0;
        checks++;
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wait_before: got %b want 0", ioctl_wait); end
        tick();
        ioctl_addr = 25'(a0 ^ 1'b1); ioctl_dout = ~d0;
        checks++;
        if (ioctl_wait !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wait_full: got %b want 1", ioctl_wait); end
        tick();
        ioctl_wr = 1'b0;
        model[a0] = d0;
        exp_we.push_back({a0, d0});
        exp_sum = exp_sum + 16'(d0);
        exp_err = 1'b1;
        checks += 2;
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wait_after: got %b want 0", ioctl_wait); end
        if (err !== exp_err) begin errors++; $display("[TB] FAIL b2b_err: got %b want %b", err, exp_err); end
        idle(3);
        checks++;
        if (we_log.size() != exp_we.size()) begin
            errors++; $display("[TB] FAIL b2b_we_count: got %0d pulses want %0d", we_log.size(), exp_we.size());
        end else begin
            checks++;
            if (we_log[0] !== exp_we[0]) begin errors++; $display("[TB] FAIL b2b_we: got %h want %h", we_log[0], exp_we[0]); end
        end
    endtask

    task automatic test_overlap();
        int         lat;
        logic [7:0] old_val;
        logic [7:0] new_val;
        we_log.delete();
        exp_we.delete();
        old_val = model[2];
        new_val = ~old_val;
        cpu_req = 1'b1; cpu_addr = 17'h00002;
        tick();
        send_byte(25'h2, new_val, 8'd0);
        lat = 2;
        while (cpu_ack !== 1'b1 && lat < 20) begin tick(); lat++; end
        cpu_req = 1'b0;
        checks += 2;
        if (lat != 3) begin errors++; $display("[TB] FAIL ovl_read_latency: got %0d want 3", lat); end
        if (cpu_rdata !== old_val) begin errors++; $display("[TB] FAIL ovl_read_data: got %h want %h", cpu_rdata, old_val); end
        idle(3);
        checks++;
        if (we_log.size() != 1 || we_log[0] !== exp_we[0]) begin
            errors++; $display("[TB] FAIL ovl_deferred_wr: got %0d pulses first %h want %h", we_log.size(), (we_log.size() > 0) ? we_log[0] : '0, exp_we[0]);
        end
        // Write and read both pending: the write goes first, costing WR plus return to IDLE.
        new_val = 8'($urandom);
        send_byte(25'h2, new_val, 8'd0);
        cpu_req = 1'b1; cpu_addr = 17'h00002;
        lat = 0;
        while (cpu_ack !== 1'b1 && lat < 20) begin tick(); lat++; end
        cpu_req = 1'b0;
        checks += 2;
        if (lat != 2 + 3) begin errors++; $display("[TB] FAIL prio_latency: got %0d want 5", lat); end
        if (cpu_rdata !== model[2]) begin errors++; $display("[TB] FAIL prio_data: got %h want %h", cpu_rdata, model[2]); end
        idle(2);
    endtask

    task automatic test_random();
        int            op;
        logic [AW-1:0] a;
        int            lat;
        logic [7:0]    d;
        logic          ack_after;
        ioctl_download = 1'b1;
        tick();
        exp_sum = 16'd0;
        we_log.delete();
        exp_we.delete();
        written.delete();
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            a  = AW'($urandom_range(0, MEMSZ - 1));
            if (op <= 5) begin
                send_byte(25'(a), 8'($urandom), 8'd0);
                written.push_back(a);
            end else if (op == 6) begin
                send_byte(25'(MEMSZ) + 25'($urandom_range(0, 32'hFFFFFF - MEMSZ)), 8'($urandom), 8'd0);
            end else if (op == 7) begin
                send_byte(25'(a), 8'($urandom), 8'd1);
            end else if (op == 8) begin
                send_byte(25'(a), 8'($urandom), 8'($urandom_range(2, 255)));
            end else begin
                tick();
            end
            idle(2);
        end
        idle(3);
        checks++;
        if (we_log.size() != exp_we.size()) begin
            errors++; $display("[TB] FAIL rnd_we_count: got %0d pulses want %0d", we_log.size(), exp_we.size());
        end else begin
            foreach (exp_we[i]) begin
                checks++;
                if (we_log[i] !== exp_we[i]) begin errors++; $display("[TB] FAIL rnd_we_%0d: got %h want %h", i, we_log[i], exp_we[i]); end
            end
        end
        checks += 3;
        if (tno !== exp_tno) begin errors++; $display("[TB] FAIL rnd_tno: got %h want %h", tno, exp_tno); end
        if (err !== exp_err) begin errors++; $display("[TB] FAIL rnd_err: got %b want %b", err, exp_err); end
        if (cksum !== expected_cksum()) begin errors++; $display("[TB] FAIL rnd_cksum: got %h want %h", cksum, expected_cksum()); end
        ioctl_download = 1'b0;
        idle(HOLD + 1);
        checks++;
        if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL rnd_release: got %b want 0", core_reset); end
        for (int k = 0; k < 12 && written.size() > 0; k++) begin
            a = written[$urandom_range(0, written.size() - 1)];
            do_read(a, lat, d, ack_after);
            checks += 2;
            if (lat != 3) begin errors++; $display("[TB] FAIL rnd_read_latency: got %0d want 3", lat); end
            if (d !== model[a]) begin errors++; $display("[TB] FAIL rnd_read_data @%h: got %h want %h", a, d, model[a]); end
        end
    endtask

    task automatic test_reset_mid_write();
        send_byte(25'h7, 8'h77, 8'd0);
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 17'h7) begin
            errors++; $display("[TB] FAIL rmw_in_wr: got we=%b addr=%h want we=1 addr=00007", mem_we, mem_addr);
        end
        reset = 1'b1;
        tick();
        checks += 2;
        if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rmw_we: got %b want 0", mem_we); end
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL rmw_wait: got %b want 0", ioctl_wait); end
        reset = 1'b0;
        exp_tno = 4'd0; exp_err = 1'b0; exp_sum = 16'd0;
        idle(HOLD + 2);
    endtask

    task automatic test_reset_mid_read();
        int acks;
        cpu_req = 1'b1; cpu_addr = 17'h00005;
        tick();
        reset = 1'b1;
        tick();
        checks += 9;
        if (mem_we !== 1'b0)     begin errors++; $display("[TB] FAIL rmr_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== '0)     begin errors++; $display("[TB] FAIL rmr_mem_addr: got %h want 0", mem_addr); end
        if (mem_din !== 8'd0)    begin errors++; $display("[TB] FAIL rmr_mem_din: got %h want 0", mem_din); end
        if (cpu_ack !== 1'b0)    begin errors++; $display("[TB] FAIL rmr_cpu_ack: got %b want 0", cpu_ack); end
        if (cpu_rdata !== 8'd0)  begin errors++; $display("[TB] FAIL rmr_cpu_rdata: got %h want 0", cpu_rdata); end
        if (ioctl_wait !== 1'b0) begin errors++; $display("[TB] FAIL rmr_wait: got %b want 0", ioctl_wait); end
        if (tno !== exp_tno)     begin errors++; $display("[TB] FAIL rmr_tno: got %h want %h", tno, exp_tno); end
        if (cksum !== 16'd0)     begin errors++; $display("[TB] FAIL rmr_cksum: got %h want 0", cksum); end
        if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL rmr_core_reset: got %b want 1", core_reset); end
        reset = 1'b0;
        cpu_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_ack === 1'b1) acks++;
            tick();
        end
        checks += 2;
        if (acks != 0) begin errors++; $display("[TB] FAIL rmr_no_ack: got %0d acks want 0", acks); end
        if (we_double !== 1'b0) begin errors++; $display("[TB] FAIL we_pulse_width: got wide pulse flag %b want 0", we_double); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        ioctl_index    = 8'd0;
        cpu_req        = 1'b0;
        cpu_addr       = '0;
        exp_tno        = 4'd0;
        exp_err        = 1'b0;
        exp_sum        = 16'd0;
        test_reset();
        test_download();
        test_title();
        test_hold_and_read();
        test_out_of_range();
        test_back_to_back();
        test_overlap();
        test_random();
        test_reset_mid_write();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
